// File: rtl/ysyx_23060025_ifu.sv
// Instruction fetch unit: issues one icache request per instruction, holds the
// fetched word for the IDU, and follows EXU/WBU redirects without losing sync with the icache.
module ysyx_23060025_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] icache_paddr,
  output logic        icache_psel,
  input  logic        icache_pready,
  input  logic [31:0] icache_prdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_fetch_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] redir_tgt;
  logic        unused_redir_lsb;

  assign redir_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redir_tgt;
      end
      // A response already in REQ is handled exactly like one in WAIT.
      S_REQ, S_WAIT: begin
        if (icache_pready && redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (icache_pready) begin
          inst_d    = icache_prdata;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end else if (redirect_valid) begin
          tgt_d   = redir_tgt;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      // The in-flight response must still be consumed before a new request.
      S_DROP: begin
        if (icache_pready) begin
          pc_d    = redirect_valid ? redir_tgt : tgt_q;
          state_d = S_REQ;
        end else if (redirect_valid) begin
          tgt_d = redir_tgt;
        end
      end
      S_HOLD: begin
        if (inst_ready) cnt_d = cnt_q + 32'd1;
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign icache_paddr   = pc_q;
  assign icache_psel    = (state_q == S_REQ);
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign perf_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060025_ifu.sv
// Directed bench for the IFU: fetch, backpressure, redirects, PC wrap, reset mid-fetch.
module tb_ysyx_23060025_ifu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] icache_paddr;
  logic        icache_psel;
  logic        icache_pready = 1'b0;
  logic [31:0] icache_prdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] perf_fetch_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  ysyx_23060025_ifu #(.RESET_PC(32'h3000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .icache_paddr   (icache_paddr),
    .icache_psel    (icache_psel),
    .icache_pready  (icache_pready),
    .icache_prdata  (icache_prdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .perf_fetch_cnt (perf_fetch_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, inst, inst_pc, perf_fetch_cnt} !==
        {1'b0, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 32'h0})
      $display("FAIL reset_state: got psel=%b valid=%b paddr=%h inst=%h pc=%h cnt=%h, exp 0 0 30000000 0 0 0",
               icache_psel, inst_valid, icache_paddr, inst, inst_pc, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_basic_fetch();
    @(posedge clock); #1;
    reset = 1'b1;
    total++;
    if ({icache_psel, inst_valid} !== 2'b00)
      $display("FAIL boot_idle: got psel=%b valid=%b, exp 0 0", icache_psel, inst_valid);
    else passed++;
    step();
    total++;
    if ({icache_psel, icache_paddr} !== {1'b1, 32'h3000_0000})
      $display("FAIL first_psel: got psel=%b paddr=%h, exp 1 30000000", icache_psel, icache_paddr);
    else passed++;
    step();
    step();
    total++;
    if ({icache_psel, inst_valid, icache_paddr} !== {1'b0, 1'b0, 32'h3000_0000})
      $display("FAIL wait_state: got psel=%b valid=%b paddr=%h, exp 0 0 30000000",
               icache_psel, inst_valid, icache_paddr);
    else passed++;
    icache_pready = 1'b1; icache_prdata = 32'h0000_0413;
    step();
    icache_pready = 1'b0; icache_prdata = 32'hFFFF_FFFF;
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0413, 32'h3000_0000})
      $display("FAIL basic_hold: got valid=%b inst=%h pc=%h, exp 1 00000413 30000000",
               inst_valid, inst, inst_pc);
    else passed++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({inst_valid, icache_psel, inst, inst_pc} !== {1'b1, 1'b0, 32'h0000_0413, 32'h3000_0000})
        $display("FAIL backpressure_%0d: got valid=%b psel=%b inst=%h pc=%h, exp 1 0 00000413 30000000",
                 i, inst_valid, icache_psel, inst, inst_pc);
      else passed++;
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, perf_fetch_cnt} !== {1'b1, 1'b0, 32'h3000_0004, 32'd1})
      $display("FAIL handshake_next: got psel=%b valid=%b paddr=%h cnt=%0d, exp 1 0 30000004 1",
               icache_psel, inst_valid, icache_paddr, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_redirect_wait();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h3000_0102;
    step();
    redirect_valid = 1'b0; redirect_pc = '0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr} !== {1'b0, 1'b0, 32'h3000_0004})
      $display("FAIL drop_state: got psel=%b valid=%b paddr=%h, exp 0 0 30000004",
               icache_psel, inst_valid, icache_paddr);
    else passed++;
    icache_pready = 1'b1; icache_prdata = 32'hDEAD_BEEF;
    step();
    icache_pready = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, inst, inst_pc, perf_fetch_cnt} !==
        {1'b1, 1'b0, 32'h3000_0100, 32'h0000_0413, 32'h3000_0000, 32'd1})
      $display("FAIL redirect_wait: got psel=%b valid=%b paddr=%h inst=%h pc=%h cnt=%0d, exp 1 0 30000100 00000413 30000000 1",
               icache_psel, inst_valid, icache_paddr, inst, inst_pc, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_coincident();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h3000_0200;
    icache_pready = 1'b1; icache_prdata = 32'hBAD0_BAD0;
    step();
    redirect_valid = 1'b0; icache_pready = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, inst} !== {1'b1, 1'b0, 32'h3000_0200, 32'h0000_0413})
      $display("FAIL coinc_wait: got psel=%b valid=%b paddr=%h inst=%h, exp 1 0 30000200 00000413",
               icache_psel, inst_valid, icache_paddr, inst);
    else passed++;
    step();
    icache_pready = 1'b1; icache_prdata = 32'h0010_0093;
    step();
    icache_pready = 1'b0;
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0093, 32'h3000_0200})
      $display("FAIL coinc_fetch: got valid=%b inst=%h pc=%h, exp 1 00100093 30000200",
               inst_valid, inst, inst_pc);
    else passed++;
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3000_0303;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    total++;
    if ({icache_psel, icache_paddr, perf_fetch_cnt} !== {1'b1, 32'h3000_0300, 32'd2})
      $display("FAIL coinc_hold: got psel=%b paddr=%h cnt=%0d, exp 1 30000300 2",
               icache_psel, icache_paddr, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_wrap();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1234;
    step();
    step();
    redirect_pc = 32'hFFFF_FFFD; icache_pready = 1'b1; icache_prdata = 32'h1111_1111;
    step();
    redirect_valid = 1'b0; icache_pready = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr} !== {1'b1, 1'b0, 32'hFFFF_FFFC})
      $display("FAIL drop_latest: got psel=%b valid=%b paddr=%h, exp 1 0 fffffffc",
               icache_psel, inst_valid, icache_paddr);
    else passed++;
    step();
    icache_pready = 1'b1; icache_prdata = 32'h0000_0013;
    step();
    icache_pready = 1'b0;
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0013, 32'hFFFF_FFFC})
      $display("FAIL wrap_hold: got valid=%b inst=%h pc=%h, exp 1 00000013 fffffffc",
               inst_valid, inst, inst_pc);
    else passed++;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    total++;
    if ({icache_psel, icache_paddr, perf_fetch_cnt} !== {1'b1, 32'h0000_0000, 32'd3})
      $display("FAIL wrap_pc: got psel=%b paddr=%h cnt=%0d, exp 1 00000000 3",
               icache_psel, icache_paddr, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    icache_pready = 1'b1; icache_prdata = 32'h0000_0033;
    step();
    icache_pready = 1'b0;
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0033, 32'h0000_0000})
      $display("FAIL pready_in_req: got valid=%b inst=%h pc=%h, exp 1 00000033 00000000",
               inst_valid, inst, inst_pc);
    else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, perf_fetch_cnt} !== {1'b1, 1'b0, 32'h0000_0040, 32'd3})
      $display("FAIL hold_redirect: got psel=%b valid=%b paddr=%h cnt=%0d, exp 1 0 00000040 3",
               icache_psel, inst_valid, icache_paddr, perf_fetch_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({icache_psel, inst_valid, icache_paddr, inst, perf_fetch_cnt} !==
        {1'b0, 1'b0, 32'h3000_0000, 32'h0, 32'h0})
      $display("FAIL async_reset: got psel=%b valid=%b paddr=%h inst=%h cnt=%0d, exp 0 0 30000000 0 0",
               icache_psel, inst_valid, icache_paddr, inst, perf_fetch_cnt);
    else passed++;
    @(posedge clock); #1;
    reset = 1'b1;
    icache_pready = 1'b1; icache_prdata = 32'hCAFE_F00D;
    step();
    icache_pready = 1'b0;
    total++;
    if ({icache_psel, inst_valid, icache_paddr} !== {1'b1, 1'b0, 32'h3000_0000})
      $display("FAIL reset_refetch: got psel=%b valid=%b paddr=%h, exp 1 0 30000000",
               icache_psel, inst_valid, icache_paddr);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({icache_psel, inst_valid} !== 2'b00)
        $display("FAIL boot_pready_ignored_%0d: got psel=%b valid=%b, exp 0 0",
                 i, icache_psel, inst_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_coincident();
    test_wrap();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_ifu.md
YSYX_23060025_IFU -- requirements
Module: ysyx_23060025_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h3000_0000: address of the first fetch after reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 icache_paddr  output  32  fetch address to the icache; equals the PC register.
REQ-005 icache_psel  output  1  fetch request to the icache; high for exactly one cycle per request.
REQ-006 icache_pready  input  1  one-cycle pulse from the icache; icache_prdata is valid in that cycle.
REQ-007 icache_prdata  input  32  fetched instruction word.
REQ-008 inst_valid  output  1  instruction available to the IDU.
REQ-009 inst_ready  input  1  IDU accepts the instruction.
REQ-010 inst  output  32  held instruction word.
REQ-011 inst_pc  output  32  PC of the held instruction.
REQ-012 redirect_valid  input  1  EXU/WBU control-flow redirect, one-cycle pulse.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 perf_fetch_cnt  output  32  count of instructions handed to the IDU.

Function
REQ-015 The block SHALL implement the states BOOT, REQ, WAIT, DROP and HOLD in a registered FSM.
REQ-016 icache_psel SHALL be 1 only in REQ; inst_valid SHALL be 1 only in HOLD.
REQ-017 icache_paddr SHALL stay constant from REQ until the cycle icache_pready is sampled, because the icache reads the address combinationally for the whole transaction.
REQ-018 BOOT -> REQ unconditionally.
- On redirect in BOOT: PC := target.
REQ-019 REQ -> WAIT.
- On redirect in REQ: go to DROP and latch the target.
- icache_pready in REQ SHALL be treated as in WAIT.
REQ-020 WAIT with icache_pready and no redirect -> HOLD.
- inst := icache_prdata; inst_pc := PC.
- inst_valid rises in the cycle after the icache_pready pulse.
REQ-021 WAIT with redirect and no icache_pready -> DROP, latching the target.
REQ-022 WAIT with redirect and icache_pready in the same cycle: discard the data, PC := target, go to REQ.
REQ-023 DROP SHALL wait for icache_pready and discard the data, then go to REQ with PC := latched target.
- A further redirect in DROP overwrites the latched target (latest wins).
- A redirect coincident with icache_pready in DROP SHALL use the new target.
REQ-024 HOLD SHALL keep inst and inst_pc stable while inst_valid is high and inst_ready is low.
REQ-025 HOLD with inst_valid & inst_ready and no redirect: PC := PC + 4, go to REQ, so icache_psel is high in the next cycle.
REQ-026 HOLD with redirect and no handshake: drop the instruction, PC := target, go to REQ.
REQ-027 HOLD with redirect and handshake in the same cycle: the transfer counts as completed (IDU flushes it), PC := target, go to REQ.
REQ-028 Every redirect target SHALL be forced word-aligned: {redirect_pc[31:2], 2'b00}.
REQ-029 PC + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-030 perf_fetch_cnt SHALL increment by 1 on each inst_valid & inst_ready cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-031 Discarded fetches SHALL NOT modify inst, inst_pc or perf_fetch_cnt.

Reset
REQ-032 While reset is 0, asynchronously:
- state = BOOT; PC = RESET_PC; latched target = 0.
- inst = 0; inst_pc = 0; perf_fetch_cnt = 0.
- icache_psel = 0; inst_valid = 0.
REQ-033 Reset asserted in WAIT or DROP SHALL abandon the fetch.
- The first icache_pready after reset release, if it arrives while in BOOT, SHALL be ignored.

Verification
REQ-034 Basic fetch: release reset; icache returns 32'h0000_0413 two cycles after psel.
- Expect psel with paddr 32'h3000_0000 in the 2nd cycle after release.
- Expect inst_valid, inst = 32'h0000_0413, inst_pc = 32'h3000_0000.
REQ-035 Backpressure: inst_ready low for 5 cycles.
- Expect inst and inst_pc stable and no psel during those cycles.
- On the handshake, expect psel next cycle with paddr 32'h3000_0004 and perf_fetch_cnt = 1.
REQ-036 Redirect in WAIT: redirect_pc = 32'h3000_0102 one cycle before pready.
- Expect the data discarded and no inst_valid.
- Expect the next psel at paddr 32'h3000_0100.
REQ-037 Coincident events: (a) redirect with pready in WAIT; (b) redirect with inst_ready in HOLD.
- (a) Expect psel next cycle at the target.
- (b) Expect perf_fetch_cnt incremented and psel next cycle at the target.
REQ-038 Wrap: redirect to 32'hFFFF_FFFC, then handshake -> expect next paddr 32'h0000_0000.
REQ-039 Reset mid-fetch: assert reset in WAIT, pulse pready during BOOT.
- Expect no inst_valid.
- Expect a fresh psel at RESET_PC.
